// File: rtl/cpu_nic_pkg.sv
// Shared constants and types for the processor/router network interface.
package cpu_nic_pkg;

  localparam int DATA_W = 64;

  // Processor-visible register map
  localparam logic [1:0] ADDR_IN_BUF     = 2'b00;
  localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF    = 2'b10;
  localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

  // Output-side send sequencer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HOLD  = 2'b01,
    ST_SEND  = 2'b10
  } send_state_e;

endpackage

// File: rtl/nic_buffer.sv
// Single-entry packet buffer with a full flag.
// Data is kept after clr; only the flag drops. Reset zeroes both.
module nic_buffer #(
  parameter int W = cpu_nic_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clr,
  input  logic [0:W-1] d,
  output logic [0:W-1] q,
  output logic         full
);

  logic [0:W-1] data_q, data_d;
  logic         full_q, full_d;

  // Next-state: load wins over clear
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load) begin
      data_d = d;
      full_d = 1'b1;
    end else if (clr) begin
      full_d = 1'b0;
    end
  end

  // Entry and flag registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign q    = data_q;
  assign full = full_q;

endmodule

// File: rtl/cpu_nic.sv
// Network interface between a processor register port and a router link.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | out_buf free; a processor write to the out-buf is accepted
// ST_HOLD  | packet held; waiting for router ready and matching polarity
// ST_SEND  | net_so high for this single cycle, then back to ST_EMPTY
//
// Data words use [0:DATA_W-1] ordering, so bit 0 is the MSB and the
// status flag in a status read lands at bit DATA_W-1 (value 1).
module cpu_nic #(
  parameter int DATA_W = cpu_nic_pkg::DATA_W,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  import cpu_nic_pkg::*;

  send_state_e state_q, state_d;

  logic [0:DATA_W-1] in_buf, out_buf;
  logic              in_full, out_full;
  logic              in_load, in_clr;
  logic              out_load, out_clr;
  logic              rd_in_buf, wr_out_buf;

  assign rd_in_buf  = nicEn && !nicWrEn && (addr == ADDR_IN_BUF);
  assign wr_out_buf = nicEn &&  nicWrEn && (addr == ADDR_OUT_BUF);

  // Router side: accept only into an empty entry; a processor read drains it
  assign in_load = net_si && !in_full;
  assign in_clr  = rd_in_buf;

  nic_buffer #(.W(DATA_W)) u_in_buf (
    .clk   (clk),
    .reset (reset),
    .load  (in_load),
    .clr   (in_clr),
    .d     (net_di),
    .q     (in_buf),
    .full  (in_full)
  );

  nic_buffer #(.W(DATA_W)) u_out_buf (
    .clk   (clk),
    .reset (reset),
    .load  (out_load),
    .clr   (out_clr),
    .d     (d_in),
    .q     (out_buf),
    .full  (out_full)
  );

  // Send sequencer state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Send sequencer next-state and buffer control; writes outside EMPTY are dropped
  always_comb begin
    state_d  = state_q;
    out_load = 1'b0;
    out_clr  = 1'b0;
    net_so   = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (wr_out_buf && !out_full) begin
          out_load = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (net_ro && (out_buf[0] == net_polarity)) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        net_so  = 1'b1;
        out_clr = 1'b1;
        state_d = ST_EMPTY;
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Processor read mux; status words carry the flag in the last bit
  always_comb begin
    d_out = '0;
    case (addr)
      ADDR_IN_BUF:     d_out = in_buf;
      ADDR_IN_STATUS:  d_out = {{(DATA_W-1){1'b0}}, in_full};
      ADDR_OUT_BUF:    d_out = out_buf;
      ADDR_OUT_STATUS: d_out = {{(DATA_W-1){1'b0}}, out_full};
      default:         d_out = '0;
    endcase
  end

  assign net_ri = !in_full;
  assign net_do = out_buf;

endmodule

// File: doc/cpu_nic.md
CPU_NIC -- requirements
Module: cpu_nic

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- DATA_W, 64, packet and processor data width, bit 0 = MSB ([0:DATA_W-1] ordering).
- ADDR_W, 2, NIC register address width.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning. Clock and reset come first.
- clk, in, 1, single clock; all state changes on the rising edge.
- reset, in, 1, synchronous, active-low reset.
- addr, in, 2, register select from the processor (00 in-buf, 01 in-status, 10 out-buf, 11 out-status).
- d_in, in, 64, processor write data.
- d_out, out, 64, processor read data.
- nicEn, in, 1, processor access strobe.
- nicWrEn, in, 1, 1 = write, 0 = read (valid only while nicEn=1).
- net_si, in, 1, router-to-NIC send valid.
- net_ri, out, 1, NIC ready to accept from the router.
- net_di, in, 64, router-to-NIC packet.
- net_so, out, 1, NIC-to-router send valid.
- net_ro, in, 1, router ready to accept from the NIC.
- net_do, out, 64, NIC-to-router packet.
- net_polarity, in, 1, router's current virtual-channel phase.

Function
REQ-003 The block SHALL hold two one-entry 64-bit buffers: in_buf with flag in_full, and out_buf with flag out_full.
REQ-004 net_ri SHALL equal !in_full, combinationally.
REQ-005 On the edge where net_si=1 and in_full=0, the block SHALL load net_di into in_buf and set in_full=1.
REQ-006 net_si=1 while in_full=1 SHALL be ignored; in_buf SHALL remain unchanged.
REQ-007 d_out SHALL be combinational:
- in_buf for addr 00.
- {63'b0, in_full} for addr 01.
- out_buf for addr 10.
- {63'b0, out_full} for addr 11.
- Status flags sit at bit 63.
REQ-008 A read of addr 00 (nicEn=1, nicWrEn=0) SHALL clear in_full on that edge; net_ri SHALL rise in the following cycle.
REQ-009 A write to addr 10 with out_full=0 SHALL load d_in into out_buf and set out_full=1 on that edge.
REQ-010 A write to addr 10 with out_full=1 SHALL be dropped. Writes to addr 00, 01 and 11 SHALL have no effect.
REQ-011 Send state machine states:
- EMPTY: out_full=0. Moves to HOLD on a REQ-009 write.
- HOLD: out_full=1, waiting. Moves to SEND when net_ro=1 and out_buf[0]==net_polarity.
- SEND: net_so=1 for exactly one cycle and net_do=out_buf. Returns to EMPTY on the next edge.
REQ-012 net_do SHALL be driven with out_buf in every state. net_so SHALL be asserted only in SEND.
REQ-013 In SEND, a processor write to addr 10 SHALL be dropped. A new write is accepted no earlier than the first cycle back in EMPTY.
REQ-014 Back-to-back processor-to-router packets SHALL be spaced at a minimum of 3 cycles (write, hold/decide, send).
REQ-015 Reads SHALL have no side effects except the REQ-008 clear. A status read SHALL never change state.

Reset
REQ-016 While reset=0 at a rising edge, the block SHALL clear in_full and out_full, zero both buffers, and enter EMPTY.
REQ-017 While in reset, outputs SHALL be: net_so=0, net_ri=1, net_do=0, d_out per REQ-007 on zeroed state.
REQ-018 Reset asserted mid-SEND SHALL abort the send: net_so=0 from the next cycle, and the packet is discarded.

Structure
REQ-019 A shared package cpu_nic_pkg SHALL hold DATA_W, the four register address constants, and the send state enumeration.
REQ-020 One sub-module, nic_buffer, SHALL implement a single 64-bit entry with load, clear and a full flag. The block SHALL instantiate it twice.

Verification
REQ-021 Router sends 64'hA5A5_0000_0000_0001 with net_si=1 → in_full=1 and net_ri=0 next cycle; read addr 01 → d_out=64'h1; read addr 00 → d_out=A5A5_0000_0000_0001 and net_ri=1 next cycle.
REQ-022 Processor writes 64'h8000_0000_0000_00FF to addr 10; net_ro=1, net_polarity=1 → net_so=1 for one cycle with net_do=8000_0000_0000_00FF, then addr 11 reads 0.
REQ-023 Same packet with net_polarity=0 for 5 cycles → net_so stays 0 and out_full=1. Polarity then goes to 1 → send occurs in the next cycle.
REQ-024 Second write to addr 10 while HOLD → out_buf keeps the first value, and only the first packet is sent.
REQ-025 net_si=1 with a new packet while in_full=1 → in_buf is unchanged. Pulse reset=0 during SEND → net_so=0, out_full=0, net_ri=1.
